// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute. Drives the single-port data
// memory, owns the stack pointer and the {CF,NF,ZF} flags register, sequences
// CALL/RET/RTI over several cycles (stalling upstream), registers the MEM/WB
// bundle and returns a combinational forwarding triple to execute.
//
// Ports:
//   CLK, Reset          clock; asynchronous active-high reset
//   Valid_In            execute bundle valid
//   ALU_Result          effective address (LDD/STD) or write-back data
//   Rsrc_Value          store / push data
//   Next_PC             return address pushed by CALL
//   In_Port             IN instruction data
//   Rdst_Addr           destination register
//   CF_In/NF_In/ZF_In   ALU flags, latched when Flags_Update
//   PUSH..STD, IN, WB   op / write-back control bits
//   Mem_RData           asynchronous memory read data
//   Mem_Addr/WData/Rd/Wr  combinational memory interface
//   Stall               upstream holds its bundle
//   Flags               {CF,NF,ZF} register
//   PC_Load/PC_Value    registered return-address load for fetch
//   WB_En/WB_Addr/WB_Data  registered write-back bundle
//   Fwd_WB/Fwd_Addr/Fwd_Val  combinational forwarding of this cycle's result
module memory_stage #(
  parameter int unsigned           ADDR_W  = 20,
  parameter logic [ADDR_W-1:0]     SP_INIT = '1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Valid_In,
  input  logic [15:0]       ALU_Result,
  input  logic [15:0]       Rsrc_Value,
  input  logic [31:0]       Next_PC,
  input  logic [15:0]       In_Port,
  input  logic [2:0]        Rdst_Addr,
  input  logic              CF_In,
  input  logic              NF_In,
  input  logic              ZF_In,
  input  logic              Flags_Update,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              CALL,
  input  logic              RET,
  input  logic              RTI,
  input  logic              LDD,
  input  logic              STD,
  input  logic              IN,
  input  logic              WB,
  input  logic [15:0]       Mem_RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_WData,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic              Stall,
  output logic [2:0]        Flags,
  output logic              PC_Load,
  output logic [31:0]       PC_Value,
  output logic              WB_En,
  output logic [2:0]        WB_Addr,
  output logic [15:0]       WB_Data,
  output logic              Fwd_WB,
  output logic [2:0]        Fwd_Addr,
  output logic [15:0]       Fwd_Val
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_W1, S_W2} state_t;
  typedef enum logic [1:0] {SEQ_CALL, SEQ_RET, SEQ_RTI} seq_t;

  state_t              state, next_state;
  seq_t                seq_op, next_seq;
  logic [ADDR_W-1:0]   sp, sp_next;
  logic [FLAG_W-1:0]   flags_q, flags_next;
  logic [DATA_W-1:0]   low_q, low_next;
  logic                pc_load_next;
  logic [PC_W-1:0]     pc_value_next;

  logic [ADDR_W-1:0]   sp_inc, sp_dec;
  logic [ADDR_W-1:0]   addr_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                rd_c, wr_c, stall_c;
  logic                fwd_wb_c;
  logic [REG_W-1:0]    fwd_addr_c;
  logic [DATA_W-1:0]   fwd_val_c;

  // Stack arithmetic wraps modulo 2^ADDR_W.
  assign sp_inc = sp + ADDR_W'(1);
  assign sp_dec = sp - ADDR_W'(1);

  // State, SP, flags, return-address and write-back registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      seq_op   <= SEQ_CALL;
      sp       <= SP_INIT;
      flags_q  <= '0;
      low_q    <= '0;
      PC_Load  <= 1'b0;
      PC_Value <= '0;
      WB_En    <= 1'b0;
      WB_Addr  <= '0;
      WB_Data  <= '0;
    end else begin
      state    <= next_state;
      seq_op   <= next_seq;
      sp       <= sp_next;
      flags_q  <= flags_next;
      low_q    <= low_next;
      PC_Load  <= pc_load_next;
      PC_Value <= pc_value_next;
      WB_En    <= fwd_wb_c;
      WB_Addr  <= fwd_addr_c;
      WB_Data  <= fwd_val_c;
    end
  end

  // Next-state, memory strobes and forwarding.
  always_comb begin
    next_state    = state;
    next_seq      = seq_op;
    sp_next       = sp;
    flags_next    = flags_q;
    low_next      = low_q;
    pc_load_next  = 1'b0;
    pc_value_next = PC_Value;
    addr_c        = '0;
    wdata_c       = '0;
    rd_c          = 1'b0;
    wr_c          = 1'b0;
    stall_c       = 1'b0;
    fwd_wb_c      = 1'b0;
    fwd_addr_c    = '0;
    fwd_val_c     = '0;

    unique case (state)
      S_IDLE: begin
        if (Valid_In) begin
          fwd_wb_c   = WB;
          fwd_addr_c = Rdst_Addr;
          fwd_val_c  = IN ? In_Port : ALU_Result;
          if (Flags_Update) flags_next = {CF_In, NF_In, ZF_In};
          // Op decode in fixed priority; RTI's flag restore overrides Flags_Update.
          if (RTI) begin
            addr_c     = sp_inc;
            rd_c       = 1'b1;
            flags_next = Mem_RData[FLAG_W-1:0];
            sp_next    = sp_inc;
            stall_c    = 1'b1;
            next_seq   = SEQ_RTI;
            next_state = S_W1;
          end else if (RET) begin
            addr_c     = sp_inc;
            rd_c       = 1'b1;
            low_next   = Mem_RData;
            sp_next    = sp_inc;
            stall_c    = 1'b1;
            next_seq   = SEQ_RET;
            next_state = S_W2;
          end else if (CALL) begin
            addr_c     = sp;
            wdata_c    = Next_PC[31:16];
            wr_c       = 1'b1;
            sp_next    = sp_dec;
            stall_c    = 1'b1;
            next_seq   = SEQ_CALL;
            next_state = S_W2;
          end else if (POP) begin
            addr_c    = sp_inc;
            rd_c      = 1'b1;
            sp_next   = sp_inc;
            fwd_val_c = Mem_RData;
          end else if (PUSH) begin
            addr_c  = sp;
            wdata_c = Rsrc_Value;
            wr_c    = 1'b1;
            sp_next = sp_dec;
          end else if (LDD) begin
            addr_c    = ADDR_W'(ALU_Result);
            rd_c      = 1'b1;
            fwd_val_c = Mem_RData;
          end else if (STD) begin
            addr_c  = ADDR_W'(ALU_Result);
            wdata_c = Rsrc_Value;
            wr_c    = 1'b1;
          end
        end
      end
      // RTI only: pop the low return-address word.
      S_W1: begin
        addr_c     = sp_inc;
        rd_c       = 1'b1;
        low_next   = Mem_RData;
        sp_next    = sp_inc;
        stall_c    = 1'b1;
        next_state = S_W2;
      end
      // Final word of the sequence; stall drops so upstream advances here.
      S_W2: begin
        if (seq_op == SEQ_CALL) begin
          addr_c  = sp;
          wdata_c = Next_PC[15:0];
          wr_c    = 1'b1;
          sp_next = sp_dec;
        end else begin
          addr_c        = sp_inc;
          rd_c          = 1'b1;
          sp_next       = sp_inc;
          pc_load_next  = 1'b1;
          pc_value_next = {Mem_RData, low_q};
        end
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes and stall are suppressed while Reset is held so an aborted
  // sequence cannot complete a write or keep upstream frozen.
  assign Mem_Addr  = addr_c;
  assign Mem_WData = wdata_c;
  assign Mem_Rd    = rd_c & ~Reset;
  assign Mem_Wr    = wr_c & ~Reset;
  assign Stall     = stall_c & ~Reset;
  assign Flags     = flags_q;
  assign Fwd_WB    = fwd_wb_c;
  assign Fwd_Addr  = fwd_addr_c;
  assign Fwd_Val   = fwd_val_c;

endmodule
